// File: rtl/cpu_controller_if.sv
// Control bus between the accumulator-CPU sequencer and its datapath.
// The sequencer uses the slave view; the datapath or a bench uses the master view.
interface cpu_controller_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       opcode;
    logic             zero;
    logic             resume;
    logic             sel;
    logic             rd;
    logic             ld_ir;
    logic             inc_pc;
    logic             ld_pc;
    logic             ld_ac;
    logic             wr;
    logic             data_e;
    logic             halt;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instr_cnt;

    modport slave (
        input  opcode, zero, resume,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, instr_cnt
    );

    modport master (
        output opcode, zero, resume,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase, instr_cnt
    );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the 8-bit accumulator CPU, with a
// latched halt state and a saturating retired-instruction counter.
module cpu_controller #(
    parameter int CNT_W = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    cpu_controller_if.slave  bus
);

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_instrCnt;

    logic w_isAlu, w_isHlt, w_isSkz, w_isSto, w_isJmp;
    logic w_retire;
    logic w_sel, w_rd, w_ldIr, w_incPc, w_ldPc, w_ldAc, w_wr, w_dataE, w_halt;

    // Unknown or illegal opcodes match no item and decode as a plain non-ALU op.
    always_comb begin
        w_isAlu = 1'b0;
        w_isHlt = 1'b0;
        w_isSkz = 1'b0;
        w_isSto = 1'b0;
        w_isJmp = 1'b0;
        case (bus.opcode)
            OP_HLT:                         w_isHlt = 1'b1;
            OP_SKZ:                         w_isSkz = 1'b1;
            OP_ADD, OP_AND, OP_XOR, OP_LDA: w_isAlu = 1'b1;
            OP_STO:                         w_isSto = 1'b1;
            OP_JMP:                         w_isJmp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INST_ADDR;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = S_INST_ADDR;
        case (r_state)
            S_INST_ADDR:  w_nextState = S_INST_FETCH;
            S_INST_FETCH: w_nextState = S_INST_LOAD;
            S_INST_LOAD:  w_nextState = S_IDLE;
            S_IDLE:       w_nextState = S_OP_ADDR;
            S_OP_ADDR:    w_nextState = w_isHlt ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH:   w_nextState = S_ALU_OP;
            S_ALU_OP:     w_nextState = S_STORE;
            S_STORE:      w_nextState = S_INST_ADDR;
            S_HALTED:     w_nextState = bus.resume ? S_INST_ADDR : S_HALTED;
            default:      w_nextState = S_INST_ADDR;
        endcase
    end

    // HLT retires on entry to HALTED; every other opcode retires leaving STORE.
    assign w_retire = (r_state == S_STORE) || ((r_state == S_OP_ADDR) && w_isHlt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instrCnt <= '0;
        end else if (w_retire && (r_instrCnt != CNT_MAX)) begin
            r_instrCnt <= r_instrCnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_sel   = 1'b0;
        w_rd    = 1'b0;
        w_ldIr  = 1'b0;
        w_incPc = 1'b0;
        w_ldPc  = 1'b0;
        w_ldAc  = 1'b0;
        w_wr    = 1'b0;
        w_dataE = 1'b0;
        w_halt  = 1'b0;
        case (r_state)
            S_INST_ADDR: begin
                w_sel = 1'b1;
            end
            S_INST_FETCH: begin
                w_sel = 1'b1;
                w_rd  = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                w_sel  = 1'b1;
                w_rd   = 1'b1;
                w_ldIr = 1'b1;
            end
            S_OP_ADDR: begin
                w_incPc = 1'b1;
                w_halt  = w_isHlt;
            end
            S_OP_FETCH: begin
                w_rd = w_isAlu;
            end
            S_ALU_OP: begin
                w_rd    = w_isAlu;
                w_incPc = w_isSkz && bus.zero;
                w_ldPc  = w_isJmp;
                w_dataE = w_isSto;
            end
            S_STORE: begin
                w_rd    = w_isAlu;
                w_ldAc  = w_isAlu;
                w_incPc = w_isJmp;
                w_ldPc  = w_isJmp;
                w_dataE = w_isSto;
                w_wr    = w_isSto;
            end
            S_HALTED: begin
                w_halt = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.sel       = w_sel;
    assign bus.rd        = w_rd;
    assign bus.ld_ir     = w_ldIr;
    assign bus.inc_pc    = w_incPc;
    assign bus.ld_pc     = w_ldPc;
    assign bus.ld_ac     = w_ldAc;
    assign bus.wr        = w_wr;
    assign bus.data_e    = w_dataE;
    assign bus.halt      = w_halt;
    assign bus.phase     = (r_state == S_HALTED) ? 3'd4 : r_state[2:0];
    assign bus.instr_cnt = r_instrCnt;

endmodule
